// File: rtl/mem_interconnect_pkg.sv
// Slave address map, state encoding and sizing helpers for the memory interconnect.
package mem_interconnect_pkg;

    localparam int NSLV_MAX = 6;

    // Slave windows are half-open: base <= addr < top.
    localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
    localparam logic [31:0] ROM_TOP    = 32'h0001_0000;
    localparam logic [31:0] PRINT_BASE = 32'h1000_0000;
    localparam logic [31:0] PRINT_TOP  = 32'h1000_1000;
    localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
    localparam logic [31:0] CLINT_TOP  = 32'h0201_0000;
    localparam logic [31:0] CLIC_BASE  = 32'h0300_0000;
    localparam logic [31:0] CLIC_TOP   = 32'h0301_0000;
    localparam logic [31:0] BRAM_BASE  = 32'h8000_0000;
    localparam logic [31:0] BRAM_TOP   = 32'h8010_0000;
    localparam logic [31:0] SPARE_BASE = 32'h9000_0000;
    localparam logic [31:0] SPARE_TOP  = 32'h9000_1000;

    // Indexed by slave number: 0 rom, 1 print, 2 clint, 3 clic, 4 bram, 5 spare.
    localparam logic [NSLV_MAX-1:0][31:0] slv_base_addr =
        {SPARE_BASE, BRAM_BASE, CLIC_BASE, CLINT_BASE, PRINT_BASE, ROM_BASE};
    localparam logic [NSLV_MAX-1:0][31:0] slv_top_addr =
        {SPARE_TOP, BRAM_TOP, CLIC_TOP, CLINT_TOP, PRINT_TOP, ROM_TOP};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } ic_state_t;

    // Width of a slave index; never zero so a single-slave build still has a select bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_interconnect_decode.sv
// Combinational address decoder: host_addr match first, then lowest matching slave window.
module ic_decode
    import mem_interconnect_pkg::*;
#(
    parameter int NSLV     = 6,
    parameter int HOST_SLV = 4,
    parameter int SEL_W    = sel_width(NSLV)
) (
    input  logic [31:0]      addr,
    input  logic [31:0]      host_addr,
    output logic             hit,
    output logic [SEL_W-1:0] sel,
    output logic [31:0]      offset
);

    // Priority decode; the tohost address is not rebased so the host sees offset 0.
    always_comb begin
        hit    = 1'b0;
        sel    = '0;
        offset = '0;
        if (addr == host_addr) begin
            hit    = 1'b1;
            sel    = SEL_W'(HOST_SLV);
            offset = '0;
        end else begin
            for (int i = 0; i < NSLV; i++) begin
                if (!hit && addr >= slv_base_addr[i] && addr < slv_top_addr[i]) begin
                    hit    = 1'b1;
                    sel    = SEL_W'(i);
                    offset = addr - slv_base_addr[i];
                end
            end
        end
    end

endmodule

// File: rtl/mem_interconnect.sv
// Sequential decode / issue / wait / respond controller for the shared memory bus.
module mem_interconnect
    import mem_interconnect_pkg::*;
#(
    parameter int NSLV     = 6,
    parameter int HOST_SLV = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          host_addr,
    input  logic                 memory_valid,
    input  logic                 memory_instr,
    input  logic [31:0]          memory_addr,
    input  logic [31:0]          memory_wdata,
    input  logic [3:0]           memory_wstrb,
    output logic [31:0]          memory_rdata,
    output logic                 memory_error,
    output logic                 memory_ready,
    output logic [NSLV-1:0]      slv_valid,
    output logic                 slv_instr,
    output logic [31:0]          slv_addr,
    output logic [31:0]          slv_wdata,
    output logic [3:0]           slv_wstrb,
    input  logic [NSLV*32-1:0]   slv_rdata,
    input  logic [NSLV-1:0]      slv_ready
);

    localparam int SEL_W = sel_width(NSLV);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    ic_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] sel_q;
    logic [31:0]      addr_q, wdata_q, rdata_q;
    logic [3:0]       wstrb_q;
    logic             instr_q, err_q;

    logic             dec_hit;
    logic [SEL_W-1:0] dec_sel;
    logic [31:0]      dec_offset;
    logic             sel_ready;
    logic [31:0]      sel_rdata;
    logic             timeout_hit;

    ic_decode #(.NSLV(NSLV), .HOST_SLV(HOST_SLV), .SEL_W(SEL_W)) u_decode (
        .addr      (memory_addr),
        .host_addr (host_addr),
        .hit       (dec_hit),
        .sel       (dec_sel),
        .offset    (dec_offset)
    );

    // Pick out the selected slave's reply; other slaves' readies never reach the FSM.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready = slv_ready[i];
                sel_rdata = slv_rdata[32*i +: 32];
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; a reply in the timeout cycle takes priority.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (memory_valid) state_nxt = dec_hit ? ISSUE : RESP;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (sel_ready || timeout_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, wait counter and response registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            instr_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (memory_valid) begin
                    instr_q <= memory_instr;
                    wdata_q <= memory_wdata;
                    wstrb_q <= memory_wstrb;
                    sel_q   <= dec_sel;
                    addr_q  <= dec_offset;
                    err_q   <= !dec_hit;
                    rdata_q <= '0;
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    if (sel_ready) begin
                        rdata_q <= sel_rdata;
                        err_q   <= 1'b0;
                    end else begin
                        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                        if (timeout_hit) begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // One-hot request strobe for the selected slave, only in ISSUE.
    always_comb begin
        slv_valid = '0;
        if (state == ISSUE) begin
            for (int i = 0; i < NSLV; i++) slv_valid[i] = (sel_q == SEL_W'(i));
        end
    end

    assign slv_instr    = instr_q;
    assign slv_addr     = addr_q;
    assign slv_wdata    = wdata_q;
    assign slv_wstrb    = wstrb_q;
    assign memory_ready = (state == RESP);
    assign memory_error = (state == RESP) && err_q;
    assign memory_rdata = ((state == RESP) && !err_q) ? rdata_q : 32'h0;

endmodule

// File: tb/tb_mem_interconnect.sv
// Scoreboard bench: stimulus pushes expected slave issues and responses, a monitor compares.
module tb_mem_interconnect;
    import mem_interconnect_pkg::*;

    localparam int NSLV = 6;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [31:0]       host_addr = 32'h8000_1000;
    logic              memory_valid = 1'b0;
    logic              memory_instr = 1'b0;
    logic [31:0]       memory_addr = '0;
    logic [31:0]       memory_wdata = '0;
    logic [3:0]        memory_wstrb = '0;
    logic [31:0]       memory_rdata;
    logic              memory_error;
    logic              memory_ready;
    logic [NSLV-1:0]   slv_valid;
    logic              slv_instr;
    logic [31:0]       slv_addr;
    logic [31:0]       slv_wdata;
    logic [3:0]        slv_wstrb;
    logic [NSLV*32-1:0] slv_rdata = '0;
    logic [NSLV-1:0]   slv_ready = '0;

    mem_interconnect #(.NSLV(NSLV), .HOST_SLV(4), .TIMEOUT(8)) dut (
        .clock(clock), .reset(reset), .host_addr(host_addr),
        .memory_valid(memory_valid), .memory_instr(memory_instr),
        .memory_addr(memory_addr), .memory_wdata(memory_wdata),
        .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata),
        .memory_error(memory_error), .memory_ready(memory_ready),
        .slv_valid(slv_valid), .slv_instr(slv_instr), .slv_addr(slv_addr),
        .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb),
        .slv_rdata(slv_rdata), .slv_ready(slv_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          t0;
        int          lat;
    } resp_t;

    typedef struct {
        logic [NSLV-1:0] valid;
        logic [31:0]     addr;
        logic [31:0]     wdata;
        logic [3:0]      wstrb;
        logic            instr;
    } iss_t;

    resp_t resp_q[$];
    iss_t  iss_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    resp_cnt = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: compare every response and every slave request against the scoreboard.
    always @(negedge clock) begin
        if (memory_ready === 1'b1) begin
            resp_t e;
            resp_cnt++;
            if (resp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready actual=1 expected=0 at cycle %0d", cyc);
            end else begin
                e = resp_q.pop_front();
                check("resp_rdata", memory_rdata, e.rdata);
                check("resp_error", 32'(memory_error), 32'(e.err));
                check("resp_latency", 32'(cyc - e.t0), 32'(e.lat));
            end
        end
        if (slv_valid !== '0) begin
            iss_t s;
            if (iss_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_slv_valid actual=%b expected=0", slv_valid);
            end else begin
                s = iss_q.pop_front();
                check("slv_valid", 32'(slv_valid), 32'(s.valid));
                check("slv_addr", slv_addr, s.addr);
                check("slv_wdata", slv_wdata, s.wdata);
                check("slv_wstrb", 32'(slv_wstrb), 32'(s.wstrb));
                check("slv_instr", 32'(slv_instr), 32'(s.instr));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive a one-cycle request and push its expectations; returns in the cycle after acceptance.
    task automatic request(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic instr, input int exp_sel,
                           input logic [31:0] exp_saddr, input logic [31:0] exp_rdata,
                           input logic exp_err, input int lat);
        resp_t r;
        iss_t  s;
        if (exp_sel >= 0) begin
            s.valid = '0;
            s.valid[exp_sel] = 1'b1;
            s.addr  = exp_saddr;
            s.wdata = wdata;
            s.wstrb = wstrb;
            s.instr = instr;
            iss_q.push_back(s);
        end
        r.rdata = exp_rdata;
        r.err   = exp_err;
        r.t0    = cyc;
        r.lat   = lat;
        resp_q.push_back(r);
        memory_valid = 1'b1;
        memory_addr  = addr;
        memory_wdata = wdata;
        memory_wstrb = wstrb;
        memory_instr = instr;
        step();
        memory_valid = 1'b0;
    endtask

    task automatic reply(input int s, input logic [31:0] data);
        slv_ready[s] = 1'b1;
        slv_rdata[32*s +: 32] = data;
        step();
        slv_ready = '0;
    endtask

    task automatic wait_resp(input int target);
        for (int i = 0; i < 50 && resp_cnt < target; i++) step();
        check("resp_count", 32'(resp_cnt), 32'(target));
    endtask

    initial begin
        #2;
        check("reset_ready", 32'(memory_ready), 32'h0);
        check("reset_error", 32'(memory_error), 32'h0);
        check("reset_rdata", memory_rdata, 32'h0);
        check("reset_slv_valid", 32'(slv_valid), 32'h0);
        check("reset_slv_addr", slv_addr, 32'h0);
        step();
        step();
        reset = 1'b1;
        step();

        // bram read, reply one cycle after valid
        request(BRAM_BASE + 32'h10, 32'h0, 4'h0, 1'b0, 4, 32'h10, 32'hDEAD_BEEF, 1'b0, 3);
        step();
        reply(4, 32'hDEAD_BEEF);
        wait_resp(1);

        // unmapped write
        request(32'hFFFF_FFF0, 32'hCAFE_0001, 4'hF, 1'b0, -1, 32'h0, 32'h0, 1'b1, 1);
        wait_resp(2);

        // host address: routed to bram at offset 0
        request(32'h8000_1000, 32'h0, 4'h0, 1'b0, 4, 32'h0, 32'h55AA_55AA, 1'b0, 3);
        step();
        reply(4, 32'h55AA_55AA);
        wait_resp(3);

        // bram next to host address is rebased normally
        request(32'h8000_1004, 32'h0, 4'h0, 1'b0, 4, 32'h1004, 32'h0BAD_F00D, 1'b0, 3);
        step();
        reply(4, 32'h0BAD_F00D);
        wait_resp(4);

        // instruction fetch from rom, slave replies two cycles after valid
        request(ROM_BASE + 32'h20, 32'h0, 4'h0, 1'b1, 0, 32'h20, 32'h0000_0013, 1'b0, 4);
        step();
        step();
        reply(0, 32'h0000_0013);
        wait_resp(5);

        // partial write to print, and a spare read
        request(PRINT_BASE + 32'h4, 32'h1122_3344, 4'h3, 1'b0, 1, 32'h4, 32'h0, 1'b0, 3);
        step();
        reply(1, 32'h0);
        wait_resp(6);
        request(SPARE_BASE + 32'h8, 32'h0, 4'h0, 1'b0, 5, 32'h8, 32'hA5A5_0005, 1'b0, 3);
        step();
        reply(5, 32'hA5A5_0005);
        wait_resp(7);

        // timeout: bram never replies
        request(BRAM_BASE + 32'h40, 32'h0, 4'h0, 1'b0, 4, 32'h40, 32'h0, 1'b1, 10);
        wait_resp(8);
        request(BRAM_BASE + 32'h44, 32'h0, 4'h0, 1'b0, 4, 32'h44, 32'h7777_0044, 1'b0, 3);
        step();
        reply(4, 32'h7777_0044);
        wait_resp(9);

        // request and foreign ready during WAIT are ignored
        request(ROM_BASE + 32'h100, 32'h0, 4'h0, 1'b0, 0, 32'h100, 32'h1234_5678, 1'b0, 4);
        step();
        memory_valid = 1'b1;
        memory_addr  = PRINT_BASE;
        slv_ready[2] = 1'b1;
        slv_rdata[95:64] = 32'hBAD0_BAD0;
        step();
        memory_valid = 1'b0;
        slv_ready = '0;
        reply(0, 32'h1234_5678);
        wait_resp(10);
        for (int i = 0; i < 5; i++) step();
        check("single_resp", 32'(resp_cnt), 32'd10);

        // reset during WAIT
        request(BRAM_BASE + 32'h80, 32'h0, 4'hF, 1'b0, 4, 32'h80, 32'h0, 1'b0, 3);
        step();
        reset = 1'b0;
        #1;
        resp_q.delete();
        check("rst_ready", 32'(memory_ready), 32'h0);
        check("rst_error", 32'(memory_error), 32'h0);
        check("rst_rdata", memory_rdata, 32'h0);
        check("rst_slv_valid", 32'(slv_valid), 32'h0);
        check("rst_slv_addr", slv_addr, 32'h0);
        check("rst_slv_wstrb", 32'(slv_wstrb), 32'h0);
        step();
        reset = 1'b1;
        reply(4, 32'hFEED_FACE);
        for (int i = 0; i < 5; i++) step();
        check("no_ready_after_reset", 32'(resp_cnt), 32'd10);

        // normal service after reset
        request(CLINT_BASE + 32'hC, 32'h0, 4'h0, 1'b0, 2, 32'hC, 32'h0000_CC01, 1'b0, 3);
        step();
        reply(2, 32'h0000_CC01);
        wait_resp(11);

        check("resp_q_empty", 32'(resp_q.size()), 32'h0);
        check("iss_q_empty", 32'(iss_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
